// File: rtl/arm_regs_pkg.sv
// Processor-mode encodings, physical bank indices and controller state type
// shared by the register-bank access controller and its mapper.
package arm_regs_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [5:0] FIQ_BASE     = 6'd16;
  localparam logic [5:0] SVC_BASE     = 6'd23;
  localparam logic [5:0] ABT_BASE     = 6'd25;
  localparam logic [5:0] IRQ_BASE     = 6'd27;
  localparam logic [5:0] UND_BASE     = 6'd29;
  localparam logic [5:0] CPSR_IDX     = 6'd31;
  localparam logic [5:0] SPSR_FIQ_IDX = 6'd32;
  localparam logic [5:0] SPSR_SVC_IDX = 6'd33;
  localparam logic [5:0] SPSR_ABT_IDX = 6'd34;
  localparam logic [5:0] SPSR_IRQ_IDX = 6'd35;
  localparam logic [5:0] SPSR_UND_IDX = 6'd36;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_WR_ISSUE,
    ST_CPSR_ISSUE
  } state_e;

  // Bits outside the mask keep the current mode; bits inside take the new value.
  function automatic logic [4:0] apply_mode_mask(input logic [4:0] cur,
                                                 input logic [4:0] data,
                                                 input logic [4:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/regbank_map.sv
// Architectural register number to physical bank index for a given mode;
// unknown modes fall back to identity and raise o_illegal.
module regbank_map
  import arm_regs_pkg::*;
(
  input  logic [4:0] i_mode,
  input  logic [3:0] i_arch_reg,
  output logic [5:0] o_phys_idx,
  output logic       o_illegal
);

  logic w_sp_lr;
  logic [5:0] w_sp_lr_ofs;

  assign w_sp_lr     = (i_arch_reg == 4'd13) || (i_arch_reg == 4'd14);
  assign w_sp_lr_ofs = {5'b0, i_arch_reg[1]};

  always_comb begin
    o_phys_idx = {2'b00, i_arch_reg};
    o_illegal  = 1'b0;
    case (i_mode)
      MODE_FIQ: if (i_arch_reg >= 4'd8 && i_arch_reg <= 4'd14)
                  o_phys_idx = FIQ_BASE + {3'b000, i_arch_reg[2:0]};
      MODE_SVC: if (w_sp_lr) o_phys_idx = SVC_BASE + w_sp_lr_ofs;
      MODE_ABT: if (w_sp_lr) o_phys_idx = ABT_BASE + w_sp_lr_ofs;
      MODE_IRQ: if (w_sp_lr) o_phys_idx = IRQ_BASE + w_sp_lr_ofs;
      MODE_UND: if (w_sp_lr) o_phys_idx = UND_BASE + w_sp_lr_ofs;
      MODE_USR, MODE_SYS: o_phys_idx = {2'b00, i_arch_reg};
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regbank_access_ctrl.sv
// Serialises operand reads, writebacks and CPSR writes onto one register-bank port.
// state | meaning: IDLE arbitrate | RD_ISSUE addrs+active | RD_CAPTURE sample bank | WR_ISSUE w/pc_w | CPSR_ISSUE cpsr_w
module regbank_access_ctrl
  import arm_regs_pkg::*;
#(
  parameter logic [31:0] PC_OFFSET  = 32'd8,
  parameter logic [4:0]  RESET_MODE = 5'b10011
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rd_valid,
  output logic        o_rd_ready,
  input  logic [3:0]  i_rd_rn,
  input  logic [3:0]  i_rd_rm,
  input  logic [3:0]  i_rd_rs,
  output logic        o_rd_data_valid,
  output logic [31:0] o_rd_rn_data,
  output logic [31:0] o_rd_rm_data,
  output logic [31:0] o_rd_rs_data,
  input  logic        i_wb_valid,
  output logic        o_wb_ready,
  input  logic [3:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_cpsr_valid,
  output logic        o_cpsr_ready,
  input  logic [31:0] i_cpsr_data,
  input  logic [31:0] i_cpsr_mask_in,
  output logic [5:0]  o_bank_addr1,
  output logic [5:0]  o_bank_addr2,
  output logic [5:0]  o_bank_addr3,
  output logic        o_bank_active,
  output logic        o_bank_w,
  output logic        o_bank_pc_w,
  output logic        o_bank_cpsr_w,
  output logic [31:0] o_bank_write,
  output logic [31:0] o_bank_pc_write,
  output logic [31:0] o_bank_cpsr_write,
  output logic [31:0] o_bank_cpsr_mask,
  input  logic [31:0] i_bank_read1,
  input  logic [31:0] i_bank_read2,
  input  logic [31:0] i_bank_read3,
  input  logic [31:0] i_bank_pc_read,
  output logic [4:0]  o_cur_mode,
  output logic        o_mode_err
);

  state_e      r_state;
  logic [4:0]  r_cur_mode;
  logic        r_mode_err;
  logic [2:0]  r_pc_sel;
  logic [5:0]  r_addr1, r_addr2, r_addr3;
  logic        r_active, r_w, r_pc_w, r_cpsr_w, r_rd_data_valid;
  logic [31:0] r_write, r_pc_write, r_cpsr_write, r_cpsr_mask;
  logic [31:0] r_rn_data, r_rm_data, r_rs_data;

  logic        w_idle;
  logic [3:0]  w_arch1;
  logic [5:0]  w_phys1, w_phys2, w_phys3;
  logic        w_ill1, w_ill2, w_ill3;
  logic [31:0] w_pc_operand;

  // Gating with i_rst_n keeps every ready low while reset is held.
  assign w_idle       = (r_state == ST_IDLE) && i_rst_n;
  assign o_cpsr_ready = w_idle && i_cpsr_valid;
  assign o_wb_ready   = w_idle && i_wb_valid && !i_cpsr_valid;
  assign o_rd_ready   = w_idle && i_rd_valid && !i_wb_valid && !i_cpsr_valid;

  assign w_arch1      = i_wb_valid ? i_wb_rd : i_rd_rn;
  assign w_pc_operand = i_bank_pc_read + PC_OFFSET;

  regbank_map u_map1 (.i_mode(r_cur_mode), .i_arch_reg(w_arch1),
                      .o_phys_idx(w_phys1), .o_illegal(w_ill1));
  regbank_map u_map2 (.i_mode(r_cur_mode), .i_arch_reg(i_rd_rm),
                      .o_phys_idx(w_phys2), .o_illegal(w_ill2));
  regbank_map u_map3 (.i_mode(r_cur_mode), .i_arch_reg(i_rd_rs),
                      .o_phys_idx(w_phys3), .o_illegal(w_ill3));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_cur_mode      <= RESET_MODE;
      r_mode_err      <= 1'b0;
      r_pc_sel        <= '0;
      r_addr1         <= '0;
      r_addr2         <= '0;
      r_addr3         <= '0;
      r_active        <= 1'b0;
      r_w             <= 1'b0;
      r_pc_w          <= 1'b0;
      r_cpsr_w        <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_write         <= '0;
      r_pc_write      <= '0;
      r_cpsr_write    <= '0;
      r_cpsr_mask     <= '0;
      r_rn_data       <= '0;
      r_rm_data       <= '0;
      r_rs_data       <= '0;
    end else begin
      r_active        <= 1'b0;
      r_w             <= 1'b0;
      r_pc_w          <= 1'b0;
      r_cpsr_w        <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_mode_err      <= r_mode_err | w_ill1 | w_ill2 | w_ill3;
      case (r_state)
        ST_IDLE: begin
          if (o_cpsr_ready) begin
            r_cpsr_write <= i_cpsr_data;
            r_cpsr_mask  <= i_cpsr_mask_in;
            r_cur_mode   <= apply_mode_mask(r_cur_mode, i_cpsr_data[4:0], i_cpsr_mask_in[4:0]);
            r_cpsr_w     <= 1'b1;
            r_state      <= ST_CPSR_ISSUE;
          end else if (o_wb_ready) begin
            if (i_wb_rd == PC_REG) begin
              r_pc_w     <= 1'b1;
              r_pc_write <= i_wb_data;
            end else begin
              r_w     <= 1'b1;
              r_write <= i_wb_data;
              r_addr1 <= w_phys1;
            end
            r_state <= ST_WR_ISSUE;
          end else if (o_rd_ready) begin
            r_addr1  <= w_phys1;
            r_addr2  <= w_phys2;
            r_addr3  <= w_phys3;
            r_active <= 1'b1;
            r_pc_sel <= {i_rd_rs == PC_REG, i_rd_rm == PC_REG, i_rd_rn == PC_REG};
            r_state  <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: r_state <= ST_RD_CAPTURE;
        ST_RD_CAPTURE: begin
          r_rn_data       <= r_pc_sel[0] ? w_pc_operand : i_bank_read1;
          r_rm_data       <= r_pc_sel[1] ? w_pc_operand : i_bank_read2;
          r_rs_data       <= r_pc_sel[2] ? w_pc_operand : i_bank_read3;
          r_rd_data_valid <= 1'b1;
          r_state         <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_data_valid   = r_rd_data_valid;
  assign o_rd_rn_data      = r_rn_data;
  assign o_rd_rm_data      = r_rm_data;
  assign o_rd_rs_data      = r_rs_data;
  assign o_bank_addr1      = r_addr1;
  assign o_bank_addr2      = r_addr2;
  assign o_bank_addr3      = r_addr3;
  assign o_bank_active     = r_active;
  assign o_bank_w          = r_w;
  assign o_bank_pc_w       = r_pc_w;
  assign o_bank_cpsr_w     = r_cpsr_w;
  assign o_bank_write      = r_write;
  assign o_bank_pc_write   = r_pc_write;
  assign o_bank_cpsr_write = r_cpsr_write;
  assign o_bank_cpsr_mask  = r_cpsr_mask;
  assign o_cur_mode        = r_cur_mode;
  assign o_mode_err        = r_mode_err;

endmodule
